switcher_tx: RTL and testbench

Host-side transmitter that drives the single-wire command link into the motor/servo switcher. It holds shadow copies of the 6-bit motor-direction and servo-enable words and emits one 8-bit command frame per changed word. Each frame is preceded by a one-cycle link reset, because the receiver latches exactly one frame per reset. The transmitter and the receiver share `clk`, and the link carries one bit per `clk` cycle.

---
 rtl/switcher_pkg.sv | 23 ++
 rtl/switcher_tx_shift.sv | 34 +++
 rtl/switcher_tx.sv | 117 +++++++++++
 tb/tb_switcher_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/switcher_pkg.sv
// Shared definitions for the switcher command link, used by both the host
// transmitter and the switcher-side receiver.
package switcher_pkg;

    localparam logic [1:0] CMD_MOTOR  = 2'b00;
    localparam logic [1:0] CMD_SERVO  = 2'b01;
    localparam int         FRAME_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        GUARD,
        DATA,
        APPLY
    } state_t;

    // Frame byte goes out LSB first, so the command code leads the payload.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] cmd,
                                                          input logic [5:0] data);
        return {data, cmd};
    endfunction

endpackage

// File: rtl/switcher_tx_shift.sv
// Parallel-in / serial-out frame shifter with a bit counter that tells the
// FSM when the final data bit is on the output.
module switcher_tx_shift
    import switcher_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  shift_en,
    output logic                  bit0,
    output logic                  last_bit
);

    logic [FRAME_BITS-1:0] sreg;
    logic [2:0]            bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= frame;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sreg    <= {1'b0, sreg[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign bit0     = sreg[0];
    assign last_bit = (bit_cnt == 3'd7);

endmodule

// File: rtl/switcher_tx.sv
// Host-side transmitter for the single-wire switcher link: shadows the motor
// and servo words and sends one reset-prefixed frame per changed word.
//
// state | meaning
// IDLE  | link quiet, arbitrate between dirty words
// SYNC  | one-cycle link reset to the receiver
// GUARD | one zero bit the receiver discards
// DATA  | eight frame bits, LSB first
// APPLY | GAP_CYCLES of zero while the receiver commits the word
module switcher_tx
    import switcher_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor_dir_wr,
    input  logic [5:0] motor_dir,
    input  logic       servo_en_wr,
    input  logic [5:0] servo_en,
    output logic       link_rst,
    output logic       sda,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t                state;
    logic [5:0]            motor_sh;
    logic [5:0]            servo_sh;
    logic                  motor_dy;
    logic                  servo_dy;
    logic                  last_servo;
    logic [3:0]            gap_cnt;

    logic                  start;
    logic                  pick_motor;
    logic [FRAME_BITS-1:0] frame_in;
    logic                  sh_bit0;
    logic                  sh_last;

    always_comb begin
        pick_motor = motor_dy && (!servo_dy || last_servo);
        start      = (state == IDLE) && (motor_dy || servo_dy);
        frame_in   = pick_motor ? build_frame(CMD_MOTOR, motor_sh)
                                : build_frame(CMD_SERVO, servo_sh);
    end

    switcher_tx_shift u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .frame    (frame_in),
        .shift_en (state == DATA),
        .bit0     (sh_bit0),
        .last_bit (sh_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            motor_sh   <= 6'h00;
            servo_sh   <= 6'h00;
            motor_dy   <= 1'b1;
            servo_dy   <= 1'b1;
            last_servo <= 1'b1;
            gap_cnt    <= '0;
            link_rst   <= 1'b1;
            sda        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            link_rst   <= (state == SYNC);
            sda        <= (state == DATA) && sh_bit0;
            busy       <= (state != IDLE);
            frame_done <= (state == APPLY) && (gap_cnt == 4'd0);

            // A write landing on the load cycle keeps its dirty flag, so the new value follows.
            if (motor_dir_wr) begin
                motor_sh <= motor_dir;
                motor_dy <= 1'b1;
            end else if (start && pick_motor) begin
                motor_dy <= 1'b0;
            end
            if (servo_en_wr) begin
                servo_sh <= servo_en;
                servo_dy <= 1'b1;
            end else if (start && !pick_motor) begin
                servo_dy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        last_servo <= !pick_motor;
                        state      <= SYNC;
                    end
                end
                SYNC:  state <= GUARD;
                GUARD: state <= DATA;
                DATA: begin
                    if (sh_last) begin
                        gap_cnt <= GAP_LAST;
                        state   <= APPLY;
                    end
                end
                APPLY: begin
                    if (gap_cnt == 4'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switcher_tx.sv
// Scoreboard bench: the driver predicts frames from the link rules, a pin-level
// monitor decodes frames off link_rst/sda and compares them in order.
module tb_switcher_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motor_dir_wr = 1'b0;
    logic [5:0] motor_dir = '0;
    logic       servo_en_wr = 1'b0;
    logic [5:0] servo_en = '0;
    logic       link_rst, sda, busy, frame_done;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic       last_servo_m;

    switcher_tx #(.GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .motor_dir_wr (motor_dir_wr),
        .motor_dir    (motor_dir),
        .servo_en_wr  (servo_en_wr),
        .servo_en     (servo_en),
        .link_rst     (link_rst),
        .sda          (sda),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] mframe(input logic [5:0] d); return {d, 2'b00}; endfunction
    function automatic logic [7:0] sframe(input logic [5:0] d); return {d, 2'b01}; endfunction

    task automatic push_motor(input logic [5:0] d);
        exp_q.push_back(mframe(d));
        last_servo_m = 1'b0;
    endtask

    task automatic push_servo(input logic [5:0] d);
        exp_q.push_back(sframe(d));
        last_servo_m = 1'b1;
    endtask

    // Both words dirty at once: whichever was not sent last goes first.
    task automatic push_both(input logic [5:0] m, input logic [5:0] s);
        if (last_servo_m) begin push_motor(m); push_servo(s); end
        else              begin push_servo(s); push_motor(m); end
    endtask

    task automatic wr(input logic me, input logic [5:0] mv, input logic se, input logic [5:0] sv);
        motor_dir_wr = me; motor_dir = mv;
        servo_en_wr  = se; servo_en  = sv;
        @(negedge clk);
        motor_dir_wr = 1'b0;
        servo_en_wr  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_checks(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("rst_link_rst", link_rst, 1);
            chk("rst_sda", sda, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
        end
    endtask

    // Monitor: decodes a frame whenever link_rst rises outside reset.
    initial begin : monitor
        logic       prev = 1'b1;
        logic       abort;
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (!reset && link_rst && !prev) begin
                abort = 1'b0;
                got   = '0;
                chk("sync_busy", busy, 1);
                @(negedge clk);
                if (reset) abort = 1'b1;
                else begin
                    chk("guard_link_rst", link_rst, 0);
                    chk("guard_sda", sda, 0);
                end
                for (int k = 0; k < 8 && !abort; k++) begin
                    @(negedge clk);
                    if (reset) abort = 1'b1;
                    else got[k] = sda;
                end
                for (int g = 0; g < GAP && !abort; g++) begin
                    @(negedge clk);
                    if (reset) abort = 1'b1;
                    else begin
                        chk("apply_sda", sda, 0);
                        chk("frame_done_pos", frame_done, (g == GAP - 1) ? 1 : 0);
                    end
                end
                if (!abort) begin
                    if (exp_q.size() == 0) chk("unexpected_frame", got, 8'hFF);
                    else begin
                        want = exp_q.pop_front();
                        chk("frame_byte", got, want);
                    end
                end
            end
            prev = link_rst;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int         n;
        logic [5:0] a, b;
        last_servo_m = 1'b1;

        // Reset and the automatic initialisation frames.
        reset_checks(3);
        reset = 1'b0;
        push_motor(6'h00);
        push_servo(6'h00);
        drain();

        // Single write with latency check: link_rst rises on the third negedge.
        motor_dir_wr = 1'b1; motor_dir = 6'b101101;
        push_motor(6'b101101);
        @(negedge clk);
        motor_dir_wr = 1'b0;
        chk("lat_n1", link_rst, 0);
        @(negedge clk);
        chk("lat_n2", link_rst, 0);
        @(negedge clk);
        chk("lat_n3", link_rst, 1);
        drain();

        // Coalescing: second servo write lands while the first frame is on the wire.
        push_servo(6'h3F);
        push_servo(6'h15);
        wr(1'b0, 6'h00, 1'b1, 6'h3F);
        repeat (5) @(negedge clk);
        chk("coalesce_busy", busy, 1);
        wr(1'b0, 6'h00, 1'b1, 6'h2E);
        wr(1'b0, 6'h00, 1'b1, 6'h15);
        drain();

        // Round-robin with simultaneous writes.
        for (int i = 0; i < 4; i++) begin
            a = 6'($urandom);
            b = 6'($urandom);
            push_both(a, b);
            wr(1'b1, a, 1'b1, b);
            drain();
        end

        // Write/load collision: second write coincides with the load of the first.
        push_motor(6'h2A);
        push_motor(6'h01);
        motor_dir_wr = 1'b1; motor_dir = 6'h2A;
        @(negedge clk);
        motor_dir = 6'h01;
        @(negedge clk);
        motor_dir_wr = 1'b0;
        drain();

        // Randomized mix of single, dual and coalesced writes.
        for (int i = 0; i < 16; i++) begin
            a = 6'($urandom);
            b = 6'($urandom);
            case ($urandom_range(0, 3))
                0: begin push_motor(a); wr(1'b1, a, 1'b0, 6'h00); end
                1: begin push_servo(b); wr(1'b0, 6'h00, 1'b1, b); end
                2: begin push_both(a, b); wr(1'b1, a, 1'b1, b); end
                default: begin
                    push_motor(a);
                    push_motor(b);
                    wr(1'b1, a, 1'b0, 6'h00);
                    repeat (4) @(negedge clk);
                    wr(1'b1, b, 1'b0, 6'h00);
                end
            endcase
            drain();
        end

        // Reset after the 4th data bit of a motor frame.
        push_motor(6'h2B);
        wr(1'b1, 6'h2B, 1'b0, 6'h00);
        n = 0;
        while (!link_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_sync_seen", link_rst, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        reset_checks(4);
        reset = 1'b0;
        last_servo_m = 1'b1;
        push_motor(6'h00);
        push_servo(6'h00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
